// File: rtl/ram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_responder_pkg
// Purpose  : Shared widths, init value and FSM state type for ram_responder.
// Revision : 1.0
// ============================================================================
package ram_responder_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;

    localparam logic [DATA_W-1:0] INIT_VAL = 8'h00;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

endpackage : ram_responder_pkg
`default_nettype wire

// File: rtl/ram_array.sv
`default_nettype none
// ============================================================================
// Module   : ram_array
// Purpose  : DEPTH x DATA_W storage, one write port, one registered read port
//            with write-first bypass.
// Revision : 1.0
// ============================================================================
module ram_array
    import ram_responder_pkg::*;
#(
    parameter int DATA_W = ram_responder_pkg::DATA_W,
    parameter int ADDR_W = ram_responder_pkg::ADDR_W,
    parameter int DEPTH  = ram_responder_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage carries no reset; the top level overwrites it after every reset.
    always_ff @(posedge clk) begin
        if (rst && we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : ram_array
`default_nettype wire

// File: rtl/ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : ram_responder
// Purpose  : Synchronous data-memory responder with self-clearing init after
//            reset, registered read data and a one-cycle read-valid pulse.
// Revision : 1.0
// ============================================================================
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int                DATA_W   = ram_responder_pkg::DATA_W,
    parameter int                ADDR_W   = ram_responder_pkg::ADDR_W,
    parameter int                DEPTH    = ram_responder_pkg::DEPTH,
    parameter logic [DATA_W-1:0] INIT_VAL = ram_responder_pkg::INIT_VAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] r_addr,
    input  logic              r_enable,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    input  logic [DATA_W-1:0] w_data,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic              w_enable,
    output logic              ready
);

    localparam logic [ADDR_W:0] C_LAST_WORD = (ADDR_W + 1)'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   init_cnt_q, init_cnt_d;
    logic              r_valid_q;

    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata;
    logic              arr_re;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            r_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            r_valid_q  <= arr_re;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == C_LAST_WORD) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // While clearing, the init counter owns the write port and reads are blocked.
    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = w_addr;
        arr_wdata = w_data;
        arr_re    = 1'b0;
        case (state_q)
            ST_INIT: begin
                arr_we    = 1'b1;
                arr_waddr = init_cnt_q[ADDR_W-1:0];
                arr_wdata = INIT_VAL;
            end
            ST_READY: begin
                arr_we = w_enable;
                arr_re = r_enable;
            end
            default: begin
                arr_we = 1'b0;
            end
        endcase
    end

    ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (arr_we),
        .waddr_i (arr_waddr),
        .wdata_i (arr_wdata),
        .re_i    (arr_re),
        .raddr_i (r_addr),
        .rdata_o (r_data)
    );

    assign r_valid = r_valid_q;
    assign ready   = (state_q == ST_READY);

endmodule : ram_responder
`default_nettype wire

// File: tb/tb_ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_responder
// Purpose  : Self-checking bench for ram_responder against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_ram_responder;

    logic       clk;
    logic       rst;
    logic [3:0] r_addr;
    logic       r_enable;
    logic [7:0] r_data;
    logic       r_valid;
    logic [7:0] w_data;
    logic [3:0] w_addr;
    logic       w_enable;
    logic       ready;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: memory image plus a count of init cycles still owed.
    logic [7:0] m_mem [16];
    int         m_init_left = 16;
    logic       m_ready     = 1'b0;
    logic       m_rvalid    = 1'b0;
    logic [7:0] m_rdata     = 8'h00;

    ram_responder dut (
        .clk      (clk),
        .rst      (rst),
        .r_addr   (r_addr),
        .r_enable (r_enable),
        .r_data   (r_data),
        .r_valid  (r_valid),
        .w_data   (w_data),
        .w_addr   (w_addr),
        .w_enable (w_enable),
        .ready    (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_edge(input bit rs, input bit we, input logic [3:0] wa,
                              input logic [7:0] wd, input bit re, input logic [3:0] ra);
        if (!rs) begin
            m_init_left = 16;
            m_ready     = 1'b0;
            m_rvalid    = 1'b0;
            m_rdata     = 8'h00;
        end else if (!m_ready) begin
            m_mem[16 - m_init_left] = 8'h00;
            m_init_left--;
            if (m_init_left == 0) m_ready = 1'b1;
            m_rvalid = 1'b0;
        end else begin
            if (we) m_mem[wa] = wd;
            m_rvalid = re;
            if (re) m_rdata = m_mem[ra];
        end
    endtask

    // One clock: drive at negedge, model the posedge, check just after it.
    task automatic cyc(input bit rs, input bit we, input logic [3:0] wa,
                       input logic [7:0] wd, input bit re, input logic [3:0] ra);
        rst = rs; w_enable = we; w_addr = wa; w_data = wd; r_enable = re; r_addr = ra;
        @(posedge clk);
        model_edge(rs, we, wa, wd, re, ra);
        #1;
        check_eq("r_valid", 32'(r_valid), 32'(m_rvalid));
        check_eq("ready",   32'(ready),   32'(m_ready));
        check_eq("r_data",  32'(r_data),  32'(m_rdata));
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
    endtask

    task automatic do_reset_and_wait();
        int waited;
        cyc(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
        cyc(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
        waited = 0;
        while (!ready && waited < 40) begin
            idle();
            waited++;
        end
        check_eq("init_len", 32'(waited), 32'd16);
    endtask

    initial begin
        rst = 1'b0; w_enable = 1'b0; r_enable = 1'b0;
        w_addr = '0; r_addr = '0; w_data = '0;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        @(negedge clk);

        // Reset then idle, read every word
        do_reset_and_wait();
        for (int a = 0; a < 16; a++) begin
            cyc(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 4'(a));
            check_eq("clear_rd", 32'(r_data), 32'h00);
        end
        idle();

        // Write then read back in consecutive cycles
        cyc(1'b1, 1'b1, 4'h0, 8'h41, 1'b0, 4'h0);
        cyc(1'b1, 1'b1, 4'h1, 8'h55, 1'b0, 4'h0);
        cyc(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 4'h1);
        check_eq("rd_a1", 32'(r_data), 32'h55);
        cyc(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 4'h0);
        check_eq("rd_a0", 32'(r_data), 32'h41);
        check_eq("rv_b2b", 32'(r_valid), 32'd1);
        idle();

        // Same-address collision is write-first
        cyc(1'b1, 1'b1, 4'h6, 8'h13, 1'b1, 4'h6);
        check_eq("coll_data", 32'(r_data), 32'h13);
        check_eq("coll_valid", 32'(r_valid), 32'd1);
        // Different addresses stay independent
        cyc(1'b1, 1'b1, 4'h7, 8'h99, 1'b1, 4'h6);
        check_eq("indep", 32'(r_data), 32'h13);

        // Hold behaviour
        cyc(1'b1, 1'b1, 4'h5, 8'h02, 1'b0, 4'h0);
        cyc(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 4'h5);
        for (int k = 0; k < 4; k++) begin
            idle();
            check_eq("hold_data", 32'(r_data), 32'h02);
        end

        // Requests during INIT are ignored
        cyc(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
        for (int k = 0; k < 16; k++) begin
            if (k == 5) cyc(1'b1, 1'b1, 4'h3, 8'hFF, 1'b1, 4'h3);
            else        idle();
        end
        check_eq("init_done", 32'(ready), 32'd1);
        cyc(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 4'h3);
        check_eq("init_ign", 32'(r_data), 32'h00);

        // Mid-operation reset
        cyc(1'b1, 1'b1, 4'h3, 8'h62, 1'b0, 4'h0);
        cyc(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 4'h3);
        check_eq("pre_rst", 32'(r_data), 32'h62);
        cyc(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'h3);
        check_eq("rst_rv", 32'(r_valid), 32'd0);
        check_eq("rst_rd", 32'(r_data), 32'h00);
        begin
            int waited = 0;
            while (!ready && waited < 40) begin
                idle();
                waited++;
            end
            check_eq("reinit_len", 32'(waited), 32'd16);
        end
        cyc(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 4'h3);
        check_eq("post_rst", 32'(r_data), 32'h00);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 600; k++) begin
            cyc(($urandom_range(0, 79) != 0), 1'($urandom), 4'($urandom),
                8'($urandom), 1'($urandom), 4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ram_responder
`default_nettype wire
